// File: rtl/window_shift.sv
// Sliding-window shift line: DEPTH taps of WIDTH bits fed over a valid/ready handshake,
// announcing a complete window on first fill and then every STRIDE accepted samples.
module window_shift #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 16,
    parameter int STRIDE = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             data,
    output logic [DEPTH*WIDTH-1:0]       taps,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         win_valid,
    input  logic                         win_ready
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic [CW-1:0] C_DEPTH   = CW'(DEPTH);
    localparam logic [CW-1:0] C_FILL    = CW'(DEPTH - 1);
    localparam logic [PW-1:0] C_PH_LAST = PW'(STRIDE - 1);

    logic [CW-1:0]    r_count;
    logic [PW-1:0]    r_phase;
    logic             r_win_valid;

    logic             w_push;
    logic             w_emit;
    logic [PW-1:0]    w_phase_next;
    logic             w_win_valid_next;
    logic [WIDTH-1:0] w_tap [DEPTH];

    // The only stall source is an unconsumed window.
    assign in_ready = !(r_win_valid && !win_ready);
    assign w_push   = in_valid && in_ready && !clear;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_tap
            logic [WIDTH-1:0] r_tap;
            logic [WIDTH-1:0] w_src;

            if (gi == 0) begin : g_head
                assign w_src = data;
            end else begin : g_body
                assign w_src = w_tap[gi-1];
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_tap <= '0;
                end else if (clear) begin
                    r_tap <= '0;
                end else if (w_push) begin
                    r_tap <= w_src;
                end
            end

            assign w_tap[gi]                  = r_tap;
            assign taps[gi*WIDTH +: WIDTH]    = r_tap;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (w_push && (r_count != C_DEPTH)) begin
            r_count <= r_count + CW'(1);
        end
    end

    // Phase only advances once the line is full; the first fill always emits.
    always_comb begin
        w_emit       = 1'b0;
        w_phase_next = r_phase;
        if (w_push) begin
            if (r_count == C_FILL) begin
                w_emit       = 1'b1;
                w_phase_next = '0;
            end else if (r_count == C_DEPTH) begin
                if (r_phase == C_PH_LAST) begin
                    w_emit       = 1'b1;
                    w_phase_next = '0;
                end else begin
                    w_phase_next = r_phase + PW'(1);
                end
            end else begin
                w_phase_next = '0;
            end
        end
    end

    always_comb begin
        w_win_valid_next = r_win_valid;
        if (w_emit) begin
            w_win_valid_next = 1'b1;
        end else if (r_win_valid && win_ready) begin
            w_win_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_phase     <= '0;
            r_win_valid <= 1'b0;
        end else if (clear) begin
            r_phase     <= '0;
            r_win_valid <= 1'b0;
        end else begin
            r_phase     <= w_phase_next;
            r_win_valid <= w_win_valid_next;
        end
    end

    assign count     = r_count;
    assign full      = (r_count == C_DEPTH);
    assign win_valid = r_win_valid;

endmodule
